// File: rtl/pry2thr_pipe.sv
// Priority-to-thermometer converter built as a SPLIT-ary reduction tree with optional per-level registers.
// Latency: popcount(PIPELINE) cycles; zero (purely combinational) when PIPELINE is 0.
// Backpressure: each registered level is a valid/ready slot; ready ripples combinationally back to i_rdy.
//
// Ports:
//   clk, rst          clock and synchronous active-high reset
//   i_vld/i_rdy/i_pry input stream carrying the WIDTH-bit priority vector
//   o_vld/o_rdy       output stream handshake
//   o_thr, o_any      thermometer result and "any bit set" flag of the accepted vector
module pry2thr_pipe #(
  parameter int          WIDTH          = 32,
  parameter int          SPLIT          = 2,
  parameter              DIRECTION      = "LSB",
  parameter int          IMPLEMENTATION = 0,
  parameter int unsigned PIPELINE       = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_vld,
  output logic             i_rdy,
  input  logic [WIDTH-1:0] i_pry,
  output logic             o_vld,
  input  logic             o_rdy,
  output logic [WIDTH-1:0] o_thr,
  output logic             o_any
);

  // Number of tree levels: WIDTH must equal SPLIT**L.
  function automatic int calc_levels();
    int n;
    int w;
    n = 1;
    w = SPLIT;
    while (w < WIDTH) begin
      w = w * SPLIT;
      n = n + 1;
    end
    return n;
  endfunction

  localparam int L = calc_levels();

  // True when a register stage sits after tree level k.
  function automatic bit piped(input int k);
    return ((PIPELINE >> k) & 32'd1) == 32'd1;
  endfunction

  function automatic int calc_latency();
    int n;
    n = 0;
    for (int k = 0; k < L; k++) begin
      if (piped(k)) n = n + 1;
    end
    return n;
  endfunction

  localparam int LATENCY = calc_latency();

  localparam logic [SPLIT-1:0] ONE = {{(SPLIT-1){1'b0}}, 1'b1};

  // SPLIT-wide base converter. MSB priority is handled by mirroring the
  // vector, running the LSB rule and mirroring back. The two implementation
  // styles are functionally identical: a ripple scan, or the two's-complement
  // trick that isolates the lowest set bit and fills every position below it.
  function automatic logic [SPLIT-1:0] base_thr(input logic [SPLIT-1:0] x);
    logic [SPLIT-1:0] v;
    logic [SPLIT-1:0] iso;
    logic [SPLIT-1:0] t;
    logic [SPLIT-1:0] r;
    v   = x;
    iso = '0;
    t   = '0;
    if (DIRECTION == "MSB") begin
      for (int i = 0; i < SPLIT; i++) v[i] = x[SPLIT-1-i];
    end
    if (IMPLEMENTATION == 0) begin
      t[0] = 1'b1;
      for (int i = 1; i < SPLIT; i++) t[i] = t[i-1] & ~v[i-1];
    end else begin
      iso = v & (~v + ONE);
      // iso==0 (no bit set) makes iso-1 all ones, giving the all-ones result.
      t   = (iso - ONE) | iso;
    end
    r = t;
    if (DIRECTION == "MSB") begin
      for (int i = 0; i < SPLIT; i++) r[i] = t[SPLIT-1-i];
    end
    return r;
  endfunction

  // Per-level combinational results (entry k = output of tree level k) and
  // per-level stage registers. Only levels with their PIPELINE bit set ever
  // load; the others keep their reset value and are never selected.
  logic [L-1:0][WIDTH-1:0] thr_c;
  logic [L-1:0][WIDTH-1:0] any_c;
  logic [L-1:0]            vld_c;
  logic [L-1:0]            rdy_c;

  logic [L-1:0][WIDTH-1:0] thr_r;
  logic [L-1:0][WIDTH-1:0] any_r;
  logic [L-1:0]            vld_r;

  logic [WIDTH-1:0] thr_cur;
  logic [WIDTH-1:0] any_cur;
  logic [WIDTH-1:0] thr_nxt;
  logic [WIDTH-1:0] any_nxt;
  logic [WIDTH-1:0] bvec;
  logic             vld_cur;
  logic             rdy_cur;

  // Tree evaluation, leaves to root. The leaves are treated as a level whose
  // children are single bits: sub-thermometers all ones, any-flags = i_pry.
  // At every level the any-flags of each SPLIT-group pass through the base
  // converter, and each child's slice of the thermometer is masked by its
  // branch bit. Any-flags of level k sit in the low WIDTH/SPLIT**(k+1) bits.
  always_comb begin
    thr_c   = '1;
    any_c   = '0;
    vld_c   = '0;
    thr_cur = '1;
    any_cur = i_pry;
    vld_cur = i_vld;
    thr_nxt = '1;
    any_nxt = '0;
    bvec    = '1;
    begin
      int cw;
      cw = 1;
      for (int k = 0; k < L; k++) begin
        if (k > 0 && piped(k - 1)) begin
          thr_cur = thr_r[k-1];
          any_cur = any_r[k-1];
          vld_cur = vld_r[k-1];
        end
        bvec    = '1;
        any_nxt = '0;
        for (int g = 0; g < WIDTH / SPLIT; g++) begin
          bvec[g*SPLIT +: SPLIT] = base_thr(any_cur[g*SPLIT +: SPLIT]);
          any_nxt[g]             = |any_cur[g*SPLIT +: SPLIT];
        end
        // cw = width of each child's sub-thermometer at this level.
        for (int i = 0; i < WIDTH; i++) thr_nxt[i] = thr_cur[i] & bvec[i / cw];
        thr_c[k] = thr_nxt;
        any_c[k] = any_nxt;
        vld_c[k] = vld_cur;
        thr_cur  = thr_nxt;
        any_cur  = any_nxt;
        cw       = cw * SPLIT;
      end
    end
  end

  // Ready chain, root to leaves. rdy_c[k] is the ready seen by level k's
  // output; a registered level passes back !valid | downstream ready.
  always_comb begin
    rdy_c   = '0;
    rdy_cur = o_rdy;
    for (int k = L - 1; k >= 0; k--) begin
      rdy_c[k] = rdy_cur;
      if (piped(k)) rdy_cur = ~vld_r[k] | rdy_cur;
    end
  end

  // Stage registers. Reset restores the all-zero-input image (thermometer all
  // ones, any-flags clear) so the output is well defined while idle. Data is
  // loaded only alongside a valid, so an empty slot keeps its last contents.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_r <= '0;
      thr_r <= '1;
      any_r <= '0;
    end else begin
      for (int k = 0; k < L; k++) begin
        if (piped(k) && (~vld_r[k] | rdy_c[k])) begin
          vld_r[k] <= vld_c[k];
          if (vld_c[k]) begin
            thr_r[k] <= thr_c[k];
            any_r[k] <= any_c[k];
          end
        end
      end
    end
  end

  // With registers present, nothing is accepted in a reset cycle (it would be
  // dropped by the reset anyway). A purely combinational build ignores rst.
  assign i_rdy = (LATENCY > 0) ? (rdy_cur & ~rst) : rdy_cur;

  assign o_vld = piped(L - 1) ? vld_r[L-1]    : vld_c[L-1];
  assign o_thr = piped(L - 1) ? thr_r[L-1]    : thr_c[L-1];
  assign o_any = piped(L - 1) ? any_r[L-1][0] : any_c[L-1][0];

endmodule
